// File: rtl/gpio_wb_banked.sv
// Banked Wishbone B4 pipelined GPIO: NUM_BANKS x BANK_WIDTH pins, 2-flop input sync, level/edge IRQs, W1C status.
// Latency: ack/err 1 cycle after accept, pad->DATA_IN 2 cycles (2+DEBOUNCE_CYCLES with GPIO_DEBOUNCE_EN); stall tied 0.
module gpio_wb_banked #(
    parameter int NUM_BANKS       = 4,
    parameter int BANK_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [31:0]                      wb_adr_i,
    input  logic [31:0]                      wb_dat_i,
    output logic [31:0]                      wb_dat_o,
    input  logic                             wb_we_i,
    input  logic [3:0]                       wb_sel_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_cyc_i,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic                             wb_stall_o,
    input  logic [NUM_BANKS*BANK_WIDTH-1:0]  gpio_i,
    output logic [NUM_BANKS*BANK_WIDTH-1:0]  gpio_o,
    output logic [NUM_BANKS*BANK_WIDTH-1:0]  gpio_oe,
    output logic                             intr
);

    localparam int NW      = NUM_BANKS * BANK_WIDTH;
    localparam int BANK_AW = ADDR_WIDTH - 5;

    localparam logic [2:0] OFF_DATA_OUT = 3'd0;
    localparam logic [2:0] OFF_DIR      = 3'd1;
    localparam logic [2:0] OFF_DATA_IN  = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFF_IRQ_TYPE = 3'd4;
    localparam logic [2:0] OFF_IRQ_POL  = 3'd5;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd6;
    localparam logic [2:0] OFF_RSVD     = 3'd7;

    function automatic logic [BANK_WIDTH-1:0] merge(input logic [BANK_WIDTH-1:0] old_v,
                                                    input logic [BANK_WIDTH-1:0] new_v,
                                                    input logic [BANK_WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Request decode
    logic                  acc;
    logic [BANK_AW-1:0]    bank_sel;
    logic [2:0]            offset;
    logic                  bank_oob;
    logic                  is_err;
    logic                  wr_en;
    logic                  rd_en;
    logic [31:0]           wmask32;
    logic [BANK_WIDTH-1:0] wmask;
    logic [BANK_WIDTH-1:0] wdat;
    logic                  unused_bits;

    assign acc      = wb_cyc_i & wb_stb_i;
    assign bank_sel = wb_adr_i[ADDR_WIDTH-1:5];
    assign offset   = wb_adr_i[4:2];
    assign bank_oob = (32'(bank_sel) >= 32'(NUM_BANKS));
    assign is_err   = bank_oob | (offset == OFF_RSVD) | (wb_we_i & (offset == OFF_DATA_IN));
    assign wr_en    = acc & wb_we_i & ~is_err;
    assign rd_en    = acc & ~wb_we_i & ~is_err;
    assign wmask32  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wmask    = wmask32[BANK_WIDTH-1:0];
    assign wdat     = wb_dat_i[BANK_WIDTH-1:0];
    assign unused_bits = ^{wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0]};

    // State
    logic [NW-1:0] data_out_q, data_out_d;
    logic [NW-1:0] dir_q,      dir_d;
    logic [NW-1:0] irq_en_q,   irq_en_d;
    logic [NW-1:0] irq_type_q, irq_type_d;
    logic [NW-1:0] irq_pol_q,  irq_pol_d;
    logic [NW-1:0] irq_stat_q, irq_stat_d;
    logic [NW-1:0] sync1_q,    sync1_d;
    logic [NW-1:0] sync2_q,    sync2_d;
    logic [NW-1:0] din_prev_q, din_prev_d;
    logic          ack_q,      ack_d;
    logic          err_q,      err_d;
    logic [31:0]   dat_q,      dat_d;
    logic          intr_q,     intr_d;

    logic [NW-1:0] data_in;
    logic [NW-1:0] w1c;
    logic [NW-1:0] stat_set;
    logic [NW-1:0] rise;
    logic [NW-1:0] fall;
    logic [31:0]   rd_word;

    assign sync1_d    = gpio_i;
    assign sync2_d    = sync1_q;
    assign din_prev_d = data_in;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NW-1:0] filt_q, filt_d;
    logic [CW-1:0] cnt_q [NW];
    logic [CW-1:0] cnt_d [NW];

    // The counter measures how long sync2 has disagreed with the filtered value.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < NW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < NW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_in = filt_q;
`else
    assign data_in = sync2_q;
`endif

    assign rise = data_in & ~din_prev_q;
    assign fall = ~data_in & din_prev_q;
    assign stat_set = (irq_type_q & ((irq_pol_q & rise) | (~irq_pol_q & fall)))
                    | (~irq_type_q & ~(data_in ^ irq_pol_q));

    // Register file: read mux and byte-lane writes for the addressed bank
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_type_d = irq_type_q;
        irq_pol_d  = irq_pol_q;
        w1c        = '0;
        rd_word    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_sel == BANK_AW'(b)) begin
                case (offset)
                    OFF_DATA_OUT: begin
                        rd_word = 32'(data_out_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        if (wr_en) data_out_d[b*BANK_WIDTH +: BANK_WIDTH] =
                            merge(data_out_q[b*BANK_WIDTH +: BANK_WIDTH], wdat, wmask);
                    end
                    OFF_DIR: begin
                        rd_word = 32'(dir_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        if (wr_en) dir_d[b*BANK_WIDTH +: BANK_WIDTH] =
                            merge(dir_q[b*BANK_WIDTH +: BANK_WIDTH], wdat, wmask);
                    end
                    OFF_DATA_IN: begin
                        rd_word = 32'(data_in[b*BANK_WIDTH +: BANK_WIDTH]);
                    end
                    OFF_IRQ_EN: begin
                        rd_word = 32'(irq_en_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        if (wr_en) irq_en_d[b*BANK_WIDTH +: BANK_WIDTH] =
                            merge(irq_en_q[b*BANK_WIDTH +: BANK_WIDTH], wdat, wmask);
                    end
                    OFF_IRQ_TYPE: begin
                        rd_word = 32'(irq_type_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        if (wr_en) irq_type_d[b*BANK_WIDTH +: BANK_WIDTH] =
                            merge(irq_type_q[b*BANK_WIDTH +: BANK_WIDTH], wdat, wmask);
                    end
                    OFF_IRQ_POL: begin
                        rd_word = 32'(irq_pol_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        if (wr_en) irq_pol_d[b*BANK_WIDTH +: BANK_WIDTH] =
                            merge(irq_pol_q[b*BANK_WIDTH +: BANK_WIDTH], wdat, wmask);
                    end
                    OFF_IRQ_STAT: begin
                        rd_word = 32'(irq_stat_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        if (wr_en) w1c[b*BANK_WIDTH +: BANK_WIDTH] = wdat & wmask;
                    end
                    default: ;
                endcase
            end
        end
        // A set event in the same cycle as a W1C keeps the bit at 1
        irq_stat_d = (irq_stat_q & ~w1c) | stat_set;
    end

    assign ack_d  = acc & ~is_err;
    assign err_d  = acc & is_err;
    assign dat_d  = rd_en ? rd_word : 32'h0;
    assign intr_d = |(irq_stat_q & irq_en_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_type_q <= '0;
            irq_pol_q  <= '0;
            irq_stat_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            din_prev_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            intr_q     <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_type_q <= irq_type_d;
            irq_pol_q  <= irq_pol_d;
            irq_stat_q <= irq_stat_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            din_prev_q <= din_prev_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            intr_q     <= intr_d;
        end
    end

    // Dropping cyc discards a pending termination
    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_err_o   = err_q & wb_cyc_i;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = data_out_q;
    assign gpio_oe    = dir_q;
    assign intr       = intr_q;

endmodule
